// File: rtl/pulse_burst_sequencer_if.sv
// Control/status bundle for pulse_burst_sequencer.
// repeat_burst exists only with PULSE_BURST_REPEAT_EN ("repeat" is a reserved word).
interface pulse_burst_sequencer_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
);
  logic         ena;
  logic         start;
  logic         abort;
  logic [N-1:0] period;
  logic [M-1:0] count;
`ifdef PULSE_BURST_REPEAT_EN
  logic         repeat_burst;
`endif
  logic         pulse;
  logic         busy;
  logic         done;
  logic         err;
  logic [M-1:0] remaining;

  modport master (
    output ena, start, abort, period, count,
`ifdef PULSE_BURST_REPEAT_EN
    output repeat_burst,
`endif
    input  pulse, busy, done, err, remaining
  );

  modport slave (
    input  ena, start, abort, period, count,
`ifdef PULSE_BURST_REPEAT_EN
    input  repeat_burst,
`endif
    output pulse, busy, done, err, remaining
  );
endinterface

// File: rtl/pulse_burst_sequencer.sv
// Issues a burst of single-cycle pulses spaced by a programmable number of enabled ticks.
// Optional: PULSE_BURST_REPEAT_EN adds repeat_burst to restart the burst instead of finishing.
module pulse_burst_sequencer #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
) (
  input logic                   clk,
  input logic                   rst,
  pulse_burst_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] tick_q, tick_d;
  logic [N-1:0] per_q, per_d;
  logic [M-1:0] rem_q, rem_d;
  logic         pulse_q, pulse_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
`ifdef PULSE_BURST_REPEAT_EN
  logic [M-1:0] cnt_q, cnt_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PULSE_BURST_REPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PULSE_BURST_REPEAT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    per_d   = per_q;
    rem_d   = rem_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PULSE_BURST_REPEAT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.period == '0) begin
            err_d = 1'b1;
          end else begin
            per_d  = bus.period;
            tick_d = '0;
            rem_d  = bus.count;
`ifdef PULSE_BURST_REPEAT_EN
            cnt_d  = bus.count;
`endif
            state_d = (bus.count == '0) ? DONE : RUN;
          end
        end
      end

      RUN: begin
        // Abort wins over a terminal tick in the same cycle
        if (bus.abort) begin
          state_d = IDLE;
          tick_d  = '0;
          rem_d   = '0;
        end else if (bus.ena) begin
          if (tick_q == per_q - N'(1)) begin
            pulse_d = 1'b1;
            tick_d  = '0;
            rem_d   = rem_q - M'(1);
            if (rem_q == M'(1)) begin
`ifdef PULSE_BURST_REPEAT_EN
              if (bus.repeat_burst) begin
                rem_d = cnt_q;
              end else begin
                state_d = DONE;
              end
`else
              state_d = DONE;
`endif
            end
          end else begin
            tick_d = tick_q + N'(1);
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.pulse     = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.remaining = rem_q;

endmodule
